// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit: FSM states, access kinds,
// the timeout fill pattern and the access-type priority decode.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } acc_t;

   localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

   // A store wins over a fetch, and a fetch wins over a load.
   function automatic acc_t decode_acc(input logic mem_write,
                                       input logic ir_write,
                                       input logic adr_src);
      if (mem_write)
         return STORE;
      else if (ir_write)
         return FETCH;
      else if (adr_src)
         return LOAD;
      return NONE;
   endfunction

endpackage

// File: rtl/mem_timeout.sv
// Bus-cycle watchdog for the memory access unit: it reloads when an access starts and
// flags expiry on the TIMEOUT_CYCLES-th BUSY cycle.
module mem_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic busy,
   output logic expired
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // The counter reloads on entry to BUSY, so the first BUSY cycle sees TIMEOUT_CYCLES-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (start)
         cnt <= TC_LOAD;
      else if (busy && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign expired = busy && (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle memory access sequencer between a stalling controller and a ready-handshake bus.
// Defining MEM_TIMEOUT_EN adds the bus watchdog and the sticky BusErr output.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IRWrite,
   input  logic        MemWrite,
   input  logic        AdrSrc,
   input  logic [31:0] PC,
   input  logic [31:0] Result,
   input  logic [31:0] WriteData,
   output logic [31:0] Instr,
   output logic [31:0] OldPC,
   output logic [31:0] Data,
   output logic        Stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        BusErr
`endif
);

   // state | meaning
   // IDLE  | no access in flight; a request latches the bus fields
   // BUSY  | bus_req high, waiting for bus_ready (or timeout)
   // DONE  | result captured; Stall low so the controller advances

   state_t      state;
   acc_t        acc_d;
   acc_t        acc_q;
   logic        acc_req;
   logic        start;
   logic        tmo_hit;
   logic [31:0] cap_data;

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign acc_d    = decode_acc(MemWrite, IRWrite, AdrSrc);
   assign acc_req  = (acc_d != NONE);
   assign start    = (state == IDLE) && acc_req;
   assign cap_data = bus_ready ? bus_rdata : BAD_DATA;

   // Gated with reset so the controller is never stalled while the unit is held in reset.
   assign Stall = reset && acc_req && (state != DONE);

`ifdef MEM_TIMEOUT_EN
   logic tmo_expired;

   mem_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .busy    (state == BUSY),
      .expired (tmo_expired)
   );

   // A response arriving in the expiry cycle still counts as a good access.
   assign tmo_hit = tmo_expired && !bus_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         BusErr <= 1'b0;
      else if ((state == BUSY) && tmo_hit)
         BusErr <= 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc_q     <= NONE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         Instr     <= '0;
         OldPC     <= '0;
         Data      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc_req) begin
                  state     <= BUSY;
                  acc_q     <= acc_d;
                  bus_req   <= 1'b1;
                  bus_we    <= (acc_d == STORE);
                  bus_addr  <= AdrSrc ? Result : PC;
                  bus_wdata <= WriteData;
               end
            end
            BUSY: begin
               if (bus_ready || tmo_hit) begin
                  state   <= DONE;
                  bus_req <= 1'b0;
                  case (acc_q)
                     FETCH: begin
                        Instr <= cap_data;
                        OldPC <= PC;
                     end
                     LOAD:    Data <= cap_data;
                     default: ;
                  endcase
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit; expected accesses are queued by the
// stimulus and checked by an independent monitor. Covers MEM_TIMEOUT_EN when defined.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
   localparam int TMO  = 4;
   localparam int MAXW = 2;
`else
   localparam int TMO  = 1 << 30;
   localparam int MAXW = 6;
`endif
   localparam int          TMO_P = (TMO > 255) ? 255 : TMO;
   localparam logic [31:0] BAD   = 32'hDEADBEEF;

   logic        clk;
   logic        reset;
   logic        IRWrite, MemWrite, AdrSrc;
   logic [31:0] PC, Result, WriteData;
   logic [31:0] Instr, OldPC, Data;
   logic        Stall;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;
`ifdef MEM_TIMEOUT_EN
   logic        BusErr;
`endif

   mem_access_unit #(
      .TIMEOUT_CYCLES(TMO_P)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .IRWrite   (IRWrite),
      .MemWrite  (MemWrite),
      .AdrSrc    (AdrSrc),
      .PC        (PC),
      .Result    (Result),
      .WriteData (WriteData),
      .Instr     (Instr),
      .OldPC     (OldPC),
      .Data      (Data),
      .Stall     (Stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready)
`ifdef MEM_TIMEOUT_EN
      ,
      .BusErr    (BusErr)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] instr;
      logic [31:0] oldpc;
      logic [31:0] data;
      int          stall;
      logic        buserr;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_instr, m_oldpc, m_data;
   logic        m_buserr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: bus fields must match the queued access for every BUSY cycle; the cycle after
   // bus_req falls is DONE, where the architectural registers and the stall length are checked.
   initial begin
      logic prev_req;
      int   stall_run;
      exp_t e;
      prev_req  = 1'b0;
      stall_run = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_req  = 1'b0;
            stall_run = 0;
         end else begin
            if (bus_req) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_underflow: bus_req=1 with no expected access");
               end else begin
                  chk("bus_addr", bus_addr, sb[0].addr);
                  chk("bus_we", {31'b0, bus_we}, {31'b0, sb[0].we});
                  if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].wdata);
               end
            end
            if (prev_req && !bus_req && (sb.size() != 0)) begin
               e = sb.pop_front();
               chk("Instr", Instr, e.instr);
               chk("OldPC", OldPC, e.oldpc);
               chk("Data", Data, e.data);
               chk("stall_cycles", stall_run, e.stall);
               chk("Stall_in_done", {31'b0, Stall}, 32'd0);
`ifdef MEM_TIMEOUT_EN
               chk("BusErr", {31'b0, BusErr}, {31'b0, e.buserr});
`endif
               stall_run = 0;
            end
            if (Stall) stall_run++;
            prev_req = bus_req;
         end
      end
   end

   // One controller access: priority decode and address select are modelled from the
   // request rules; the responder waits `waits` BUSY cycles before bus_ready.
   task automatic access(input logic iw, input logic mw, input logic as,
                         input logic [31:0] pc, input logic [31:0] res,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
      exp_t e;
      bit   tmo;
      int   n;
      IRWrite   = iw;
      MemWrite  = mw;
      AdrSrc    = as;
      PC        = pc;
      Result    = res;
      WriteData = wd;
      tmo       = (waits >= TMO);
      if (!mw && iw) begin
         m_instr = tmo ? BAD : rd;
         m_oldpc = pc;
      end else if (!mw && as) begin
         m_data = tmo ? BAD : rd;
      end
      if (tmo) m_buserr = 1'b1;
      e.addr   = as ? res : pc;
      e.we     = mw;
      e.wdata  = wd;
      e.instr  = m_instr;
      e.oldpc  = m_oldpc;
      e.data   = m_data;
      e.stall  = tmo ? (1 + TMO) : (waits + 2);
      e.buserr = m_buserr;
      sb.push_back(e);
      n = 0;
      while (!bus_req && n < 4) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus_req) begin
         n_vec++;
         n_err++;
         $display("FAIL bus_req_start: got 0 expected 1 within 4 cycles");
         sb.delete();
         return;
      end
      for (int k = 0; k < waits; k++) begin
         if (!bus_req) break;
         bus_ready = 1'b0;
         Result    = $urandom;
         WriteData = $urandom;
         @(posedge clk);
         #1;
      end
      if (bus_req) begin
         bus_ready = 1'b1;
         bus_rdata = rd;
         @(posedge clk);
         #1;
      end
      bus_ready = 1'b0;
      bus_rdata = $urandom;
   endtask

   task automatic idle(input int n);
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      AdrSrc   = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("idle_bus_req", {31'b0, bus_req}, 32'd0);
         chk("idle_Stall", {31'b0, Stall}, 32'd0);
         bus_ready = 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
         @(posedge clk);
         #1;
      end
      bus_ready = 1'b0;
   endtask

   initial begin
      logic iw, mw, as;
      exp_t e;
      reset     = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      PC        = 32'h0;
      Result    = 32'h0;
      WriteData = 32'h0;
      bus_rdata = 32'h0;
      bus_ready = 1'b0;
      m_instr   = 32'h0;
      m_oldpc   = 32'h0;
      m_data    = 32'h0;
      m_buserr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Requests and responses during reset must be ignored.
      IRWrite   = 1'b1;
      PC        = 32'h44;
      bus_ready = 1'b1;
      #1;
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
      chk("rst_Stall", {31'b0, Stall}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_Instr", Instr, 32'd0);
      chk("rst_OldPC", OldPC, 32'd0);
      chk("rst_Data", Data, 32'd0);
`ifdef MEM_TIMEOUT_EN
      chk("rst_BusErr", {31'b0, BusErr}, 32'd0);
`endif
      IRWrite   = 1'b0;
      bus_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h00500093, 1);
      idle(2);
      access(1'b0, 1'b1, 1'b1, 32'h0, 32'h2004, 32'hCAFEF00D, 32'h55555555, 0);
      idle(1);
      access(1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 32'h0, 32'h12345678, (MAXW < 5) ? MAXW : 5);
      idle(1);
      access(1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 32'h0BADF00D, 32'h77777777, 1);
      idle(1);

      // Reset pulsed in the middle of a load.
      AdrSrc = 1'b1;
      Result = 32'h300;
      e.addr = 32'h300; e.we = 1'b0; e.wdata = 32'h0; e.instr = m_instr;
      e.oldpc = m_oldpc; e.data = m_data; e.stall = 0; e.buserr = m_buserr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
      reset = 1'b0;
      sb.delete();
      m_instr  = 32'h0;
      m_oldpc  = 32'h0;
      m_data   = 32'h0;
      m_buserr = 1'b0;
      #1;
      chk("midrst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("midrst_Instr", Instr, 32'd0);
      chk("midrst_Data", Data, 32'd0);
      chk("midrst_bus_addr", bus_addr, 32'd0);
      chk("midrst_Stall", {31'b0, Stall}, 32'd0);
      AdrSrc = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

`ifdef MEM_TIMEOUT_EN
      access(1'b0, 1'b0, 1'b1, 32'h0, 32'h80, 32'h0, 32'h11111111, 10);
      idle(1);
      access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'h00A00113, 0);
      idle(1);
`endif

      for (int t = 0; t < 60; t++) begin
         do begin
            iw = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            as = 1'($urandom_range(0, 1));
         end while (!(iw || mw || as));
         access(iw, mw, as, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, MAXW));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      idle(3);
      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the bus cycles allowed before an access aborts; it applies only when MEM_TIMEOUT_EN is defined.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port IRWrite, input, 1 bit: fetch request from the controller.
REQ-005 Port MemWrite, input, 1 bit: store request from the controller.
REQ-006 Port AdrSrc, input, 1 bit: address select, 0 = PC, 1 = Result.
REQ-007 Ports PC, Result and WriteData, input, 32 bits each: fetch address, data address and store data.
REQ-008 Ports Instr, OldPC and Data, output, 32 bits each: instruction register, PC of that fetch, and load data register.
REQ-009 Port Stall, output, 1 bit: the controller holds its state while Stall is 1.
REQ-010 Ports bus_req, bus_we, bus_addr[31:0] and bus_wdata[31:0], output: the memory request.
REQ-011 Ports bus_rdata[31:0] and bus_ready, input: the memory response.
REQ-012 Port BusErr, output, 1 bit: sticky timeout flag; it exists only when MEM_TIMEOUT_EN is defined.

Function
REQ-013 Access type is decoded with priority store (MemWrite) > fetch (IRWrite) > load (AdrSrc=1 with MemWrite=0).
REQ-014 Signal acc_req is 1 when any access type is active.
REQ-015 The FSM has three states: IDLE, BUSY and DONE.
REQ-016 In IDLE with acc_req=1, the next state is BUSY, and bus_addr, bus_we and bus_wdata are latched.
REQ-017 The latched address is Result when AdrSrc=1 and PC otherwise.
REQ-018 bus_we is latched as 1 only for a store.
REQ-019 In BUSY, bus_req is 1 and the latched bus fields hold constant until bus_ready=1.
REQ-020 In BUSY with bus_ready=1, the next state is DONE.
REQ-021 On fetch completion, Instr <= bus_rdata and OldPC <= PC.
REQ-022 On load completion, Data <= bus_rdata.
REQ-023 A store completion updates no register.
REQ-024 DONE always transitions to IDLE on the next cycle.
REQ-025 Stall = acc_req & (state != DONE), combinational.
REQ-026 Minimum access latency is 2 stall cycles; the controller sees Stall=0 in DONE and advances.
REQ-027 bus_ready sampled outside BUSY is ignored.
REQ-028 Request inputs changing while in BUSY do not alter the latched access.
REQ-029 acc_req=0 in IDLE keeps the FSM in IDLE with bus_req=0 and Stall=0.
REQ-030 Back-to-back requests (acc_req still 1 on return to IDLE) start a new access immediately.

Reset
REQ-031 While reset=0, the FSM is in IDLE and bus_req, bus_we and Stall are 0.
REQ-032 While reset=0, bus_addr, bus_wdata, Instr, OldPC, Data and BusErr are 0.
REQ-033 Reset asserted mid-access drops bus_req asynchronously, with no capture of pending data.

Configuration
REQ-034 With macro MEM_TIMEOUT_EN defined, a cycle counter clears on entry to BUSY and counts each BUSY cycle.
REQ-035 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without bus_ready forces DONE and sets BusErr=1.
REQ-036 On a timed-out fetch or load, the target register loads BAD_DATA (32'hDEADBEEF).
REQ-037 Once set, BusErr clears only on reset.
REQ-038 Without MEM_TIMEOUT_EN, neither the counter nor BusErr exists, and BUSY waits indefinitely.

Structure
REQ-039 Package mem_pkg holds the FSM state enum (IDLE, BUSY, DONE), the access-type enum (NONE, FETCH, LOAD, STORE) and constant BAD_DATA.
REQ-040 The timeout counter is a sub-module, mem_timeout, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-041 Fetch test: PC=0x100, IRWrite=1, bus_ready asserted on the 2nd BUSY cycle with bus_rdata=0x00500093. Required: bus_addr=0x100, Stall=1 for 3 cycles then 0, Instr=0x00500093, OldPC=0x100.
REQ-042 Store test: MemWrite=1, AdrSrc=1, Result=0x2004, WriteData=0xCAFEF00D, zero-wait bus_ready. Required: bus_we=1, bus_addr=0x2004, bus_wdata=0xCAFEF00D, and Data/Instr unchanged.
REQ-043 Load test: AdrSrc=1, Result=0x40, 5 wait states, bus_rdata=0x12345678. Required: Data=0x12345678 one cycle after DONE and Result changes mid-BUSY leave bus_addr at 0x40.
REQ-044 Reset test: reset=0 pulsed in BUSY. Required: bus_req=0 within that cycle, FSM in IDLE, and Instr=0.
REQ-045 Timeout test (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with bus_ready held at 0. Required: DONE after 4 BUSY cycles, Data=0xDEADBEEF, BusErr=1 and still 1 after the next good access.
REQ-046 Priority test: IRWrite=1 and MemWrite=1 together. Required: store performed with bus_we=1 and Instr unchanged.
